// File: rtl/wb_slave_decoder.sv
// ---------------------------------------------------------------------------
// wb_slave_decoder
//
// This block sits downstream of the EPB-to-Wishbone bridge. It takes the
// bridge's single-cycle request pulse and latches the whole request. It then
// decodes the address to one of NUM_SLAVES slave ports. The cycle is held
// toward that slave until one of three things happens: the slave acks, the
// slave errs, or the timeout expires. The bridge then gets a single-cycle ack
// or err together with registered read data.
//
// Ports
//   wb_clk_i, wb_rst_i : clock and synchronous active-high reset
//   wbs_*_i / wbs_*_o  : upstream (bridge) side; request in, ack/err/data out
//   wbm_*_o / wbm_*_i  : downstream side; one-hot cyc/stb plus shared
//                        we/sel/adr/dat out; per-slave data/ack/err in
//   timeout_o          : pulses together with an err that a timeout caused
//   req_dropped_o      : sticky flag, set by a request that arrives while busy
// ---------------------------------------------------------------------------
module wb_slave_decoder #(
  parameter int unsigned BUS_ADDR_WIDTH = 32,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*BUS_ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*BUS_ADDR_WIDTH-1:0] SLAVE_MASK =
    {4{32'hFFFF_0000}},
  parameter int unsigned TIMEOUT        = 1023
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  // bridge side
  input  logic                               wbs_cyc_i,
  input  logic                               wbs_stb_i,
  input  logic                               wbs_we_i,
  input  logic [3:0]                         wbs_sel_i,
  input  logic [BUS_ADDR_WIDTH-1:0]          wbs_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]          wbs_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]          wbs_dat_o,
  output logic                               wbs_ack_o,
  output logic                               wbs_err_o,
  // slave side
  output logic [NUM_SLAVES-1:0]              wbm_cyc_o,
  output logic [NUM_SLAVES-1:0]              wbm_stb_o,
  output logic                               wbm_we_o,
  output logic [3:0]                         wbm_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0]          wbm_adr_o,
  output logic [BUS_DATA_WIDTH-1:0]          wbm_dat_o,
  input  logic [NUM_SLAVES*BUS_DATA_WIDTH-1:0] wbm_dat_i,
  input  logic [NUM_SLAVES-1:0]              wbm_ack_i,
  input  logic [NUM_SLAVES-1:0]              wbm_err_i,
  // status
  output logic                               timeout_o,
  output logic                               req_dropped_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NUM_SLAVES-1:0]      cyc_q;
  logic                       we_q;
  logic [3:0]                 sel_q;
  logic [BUS_ADDR_WIDTH-1:0]  adr_q;
  logic [BUS_DATA_WIDTH-1:0]  wdat_q;
  logic [BUS_DATA_WIDTH-1:0]  rdat_q;
  logic                       ack_q;
  logic                       err_q;
  logic                       timeout_q;
  logic                       dropped_q;

  logic                       req;
  logic                       hit_found;
  logic [NUM_SLAVES-1:0]      hit_oh;
  logic                       slv_ack;
  logic                       slv_err;
  logic [BUS_DATA_WIDTH-1:0]  slv_rdata;
  logic                       timeout_hit;

  assign req = wbs_cyc_i & wbs_stb_i;

  // Priority address decode. Scanning upward, only the first matching slave
  // is taken, so the lowest index wins when windows overlap.
  always_comb begin
    hit_found = 1'b0;
    hit_oh    = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (!hit_found &&
          ((wbs_adr_i & SLAVE_MASK[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH]) ==
           SLAVE_BASE[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH])) begin
        hit_found = 1'b1;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // cyc_q is one-hot while in WAIT. Masking with it selects the addressed
  // slave's ack/err/data and ignores every other slave.
  assign slv_ack = |(wbm_ack_i & cyc_q);
  assign slv_err = |(wbm_err_i & cyc_q);

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (cyc_q[i]) slv_rdata = wbm_dat_i[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: state uses non-blocking assignments so that every register samples
  // values from before the edge, whatever order the statements appear in.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // NOTE: the latched request is reset as well, because those registers
      // drive ports that must read 0 out of reset.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cyc_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      // Response flags are single-cycle pulses.
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;

      if (req && state_q != ST_IDLE) dropped_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (req) begin
            adr_q  <= wbs_adr_i;
            wdat_q <= wbs_dat_i;
            sel_q  <= wbs_sel_i;
            we_q   <= wbs_we_i;
            cnt_q  <= '0;
            if (hit_found) begin
              cyc_q   <= hit_oh;
              state_q <= ST_WAIT;
            end else begin
              err_q   <= 1'b1;
              rdat_q  <= '0;
              state_q <= ST_RESP;
            end
          end
        end

        ST_WAIT: begin
          // Precedence: slave err, then slave ack, then timeout.
          if (slv_err) begin
            err_q   <= 1'b1;
            rdat_q  <= '0;
            cyc_q   <= '0;
            state_q <= ST_RESP;
          end else if (slv_ack) begin
            ack_q   <= 1'b1;
            rdat_q  <= slv_rdata;
            cyc_q   <= '0;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            rdat_q    <= '0;
            cyc_q     <= '0;
            state_q   <= ST_RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = wdat_q;
  assign wbs_dat_o     = rdat_q;
  assign wbs_ack_o     = ack_q;
  assign wbs_err_o     = err_q;
  assign timeout_o     = timeout_q;
  assign req_dropped_o = dropped_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_decoder
//
// Testbench for wb_slave_decoder, built with TIMEOUT=8. It runs a set of
// directed transactions first and then randomized ones. For each
// transaction, the expected address decode, response cycle and response kind
// come from a plain table-driven reference.
// ---------------------------------------------------------------------------
module tb_wb_slave_decoder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 8;

  // Response kinds for the modelled slave.
  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_BOTH   = 2;
  localparam int K_SILENT = 3;

  logic              clk;
  logic              rst;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [AW-1:0]     wbs_adr_i;
  logic [DW-1:0]     wbs_dat_i;
  logic [DW-1:0]     wbs_dat_o;
  logic              wbs_ack_o, wbs_err_o;
  logic [NS-1:0]     wbm_cyc_o, wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [NS*DW-1:0]  wbm_dat_i;
  logic [NS-1:0]     wbm_ack_i, wbm_err_i;
  logic              timeout_o, req_dropped_o;

  wb_slave_decoder #(
    .BUS_ADDR_WIDTH (AW),
    .BUS_DATA_WIDTH (DW),
    .NUM_SLAVES     (NS),
    .TIMEOUT        (TO)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_dat_o     (wbs_dat_o),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_err_o     (wbs_err_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_ack_i     (wbm_ack_i),
    .wbm_err_i     (wbm_err_i),
    .timeout_o     (timeout_o),
    .req_dropped_o (req_dropped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference address map.
  logic [31:0] base_tbl [NS] = '{32'h0000_0000, 32'h0001_0000,
                                 32'h0002_0000, 32'h0003_0000};
  logic [31:0] mask_tbl [NS] = '{32'hFFFF_0000, 32'hFFFF_0000,
                                 32'hFFFF_0000, 32'hFFFF_0000};

  int   errors = 0;
  int   checks = 0;
  logic model_dropped = 1'b0;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // First matching window wins; -1 means unmapped.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_tbl[i]) == base_tbl[i]) return i;
    return -1;
  endfunction

  task automatic quiet_slaves();
    wbm_ack_i = '0;
    wbm_err_i = '0;
    wbm_dat_i = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle_cyc", wbm_cyc_o, '0);
    check("idle_ack", wbs_ack_o, 1'b0);
    check("idle_err", wbs_err_o, 1'b0);
    check("idle_drop", req_dropped_o, model_dropped);
  endtask

  // One complete bridge transaction. The slave answers in cycle d after
  // capture with the given kind; drop_at>0 injects a second request in
  // that WAIT cycle.
  task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input int d,
                         input int kind, input logic [31:0] rd,
                         input int drop_at);
    int            idx;
    logic [NS-1:0] oh;
    logic          silent, exp_err;
    int            resp_at;

    idx = ref_decode(adr);
    oh  = '0;
    if (idx >= 0) oh[idx] = 1'b1;

    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wbs_adr_i = adr;  wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wbs_dat_i = $urandom; wbs_adr_i = $urandom; wbs_sel_i = 4'($urandom);
    wbs_we_i  = ~we;

    if (idx < 0) begin
      check("unm_cyc", wbm_cyc_o, '0);
      check("unm_err", wbs_err_o, 1'b1);
      check("unm_ack", wbs_ack_o, 1'b0);
      check("unm_to", timeout_o, 1'b0);
      check("unm_dat", wbs_dat_o, 32'h0);
      @(posedge clk); #1;
      check("unm_err_end", wbs_err_o, 1'b0);
      check("unm_cyc2", wbm_cyc_o, '0);
      return;
    end

    silent  = (kind == K_SILENT) || (d > TO);
    exp_err = silent || (kind != K_ACK);
    resp_at = silent ? TO + 1 : d + 1;

    for (int n = 1; n <= resp_at; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (n < resp_at) begin
        check("wait_cyc", wbm_cyc_o, oh);
        check("wait_stb", wbm_stb_o, oh);
        check("wait_ack", wbs_ack_o, 1'b0);
        check("wait_err", wbs_err_o, 1'b0);
        check("wait_drop", req_dropped_o, model_dropped);
        if (n == 1) begin
          check("lat_adr", wbm_adr_o, adr);
          check("lat_dat", wbm_dat_o, dat);
          check("lat_sel", wbm_sel_o, sel);
          check("lat_we", wbm_we_o, we);
        end
        // Other slaves chatter randomly; only the addressed one matters.
        wbm_ack_i = NS'($urandom) & ~oh;
        wbm_err_i = NS'($urandom) & ~oh;
        for (int k = 0; k < NS; k++) wbm_dat_i[k*DW +: DW] = $urandom;
        if (!silent && n == d) begin
          if (kind == K_ACK || kind == K_BOTH) wbm_ack_i = wbm_ack_i | oh;
          if (kind == K_ERR || kind == K_BOTH) wbm_err_i = wbm_err_i | oh;
          wbm_dat_i[idx*DW +: DW] = rd;
        end
        if (n == drop_at) begin
          wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
          model_dropped = 1'b1;
        end else begin
          wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        end
      end else begin
        quiet_slaves();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        check("rsp_cyc", wbm_cyc_o, '0);
        check("rsp_ack", wbs_ack_o, !exp_err);
        check("rsp_err", wbs_err_o, exp_err);
        check("rsp_to", timeout_o, silent);
        check("rsp_adr_hold", wbm_adr_o, adr);
        check("rsp_drop", req_dropped_o, model_dropped);
        if (!exp_err) check("rsp_rdata", wbs_dat_o, rd);
        if (silent)   check("rsp_to_dat", wbs_dat_o, 32'h0);
      end
    end

    @(posedge clk); #1;
    check("end_ack", wbs_ack_o, 1'b0);
    check("end_err", wbs_err_o, 1'b0);
    check("end_to", timeout_o, 1'b0);
    if (!exp_err) check("hold_rdata", wbs_dat_o, rd);
  endtask

  initial begin
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0;   wbs_adr_i = '0;   wbs_dat_i = '0;
    quiet_slaves();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_cyc", wbm_cyc_o, '0);
    check("rst_ack", wbs_ack_o, 1'b0);
    check("rst_err", wbs_err_o, 1'b0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_to", timeout_o, 1'b0);
    check("rst_drop", req_dropped_o, 1'b0);
    idle_cycle();

    // Directed cases.
    run_txn(32'h0001_0040, 32'h0, 4'hF, 1'b0, 3, K_ACK, 32'hCAFE_F00D, 0);
    idle_cycle();
    run_txn(32'h0000_0008, 32'h1234_5678, 4'hF, 1'b1, 1, K_ACK,
            32'h5A5A_0001, 0);
    run_txn(32'h8000_0000, 32'h0, 4'h3, 1'b0, 1, K_ACK, 32'h0, 0);
    run_txn(32'h0002_0100, 32'h0, 4'hF, 1'b0, 1, K_SILENT, 32'h0, 0);
    run_txn(32'h0003_0004, 32'h0, 4'hF, 1'b0, TO, K_ACK, 32'h0BAD_BEEF, 0);
    run_txn(32'h0003_0010, 32'h0, 4'h1, 1'b1, 2, K_BOTH, 32'h1111_2222, 1);
    idle_cycle();
    run_txn(32'h0001_0000, 32'h0, 4'hF, 1'b0, 1, K_ERR, 32'h3333_4444, 0);

    // Reset while in WAIT.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h0002_0000;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("rw_cyc", wbm_cyc_o, 4'b0100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_dropped = 1'b0;
    check("rw_cyc0", wbm_cyc_o, '0);
    check("rw_ack", wbs_ack_o, 1'b0);
    check("rw_err", wbs_err_o, 1'b0);
    check("rw_drop", req_dropped_o, 1'b0);
    idle_cycle();
    idle_cycle();
    run_txn(32'h0002_0020, 32'hDEAD_0001, 4'hC, 1'b1, 2, K_ACK,
            32'h7777_8888, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      int          d, kind, drop, gap;
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(4, 65535) << 16) | $urandom_range(0, 65535);
      else
        a = base_tbl[$urandom_range(0, NS - 1)] | $urandom_range(0, 65535);
      d    = $urandom_range(1, TO + 2);
      kind = $urandom_range(0, 3);
      drop = ($urandom_range(0, 9) == 0) ? 1 : 0;
      run_txn(a, $urandom, 4'($urandom), 1'($urandom), d, kind, $urandom,
              drop);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
